// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: req/ack data-memory access with byte lanes, load alignment and stall.
// Optional macro MEM_WB_RESULT_EN adds the result_w writeback mux output.
module mem_wb_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall_m,
  input  logic        regwrite_m,
  input  logic        memtoreg_m,
  input  logic        memwrite_m,
  input  logic [31:0] aluout_m,
  input  logic [31:0] writedata_m,
  input  logic [4:0]  writereg_m,
  input  logic [31:0] a0_m,
  input  logic [31:0] v0_m,
  input  logic [31:0] instr_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_m,
  output logic        syscall_w,
  output logic        regwrite_w,
  output logic        memtoreg_w,
  output logic [31:0] readdata_w,
  output logic [31:0] aluout_w,
  output logic [4:0]  writereg_w,
  output logic [31:0] a0_w,
  output logic [31:0] v0_w,
  output logic [31:0] instr_w,
  output logic        misalign_w,
  output logic        buserr_w
`ifdef MEM_WB_RESULT_EN
  ,
  output logic [31:0] result_w
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic        memop, is_byte, is_half, is_word, is_unsigned;
  logic        misaligned, access, timeout_hit;
  logic        done, buserr_hit, misalign_hit;
  logic [1:0]  lane;
  logic [31:0] rshift, load_data;

  // Access size comes from opcode bits [27:26]; bit 28 marks the unsigned loads.
  assign memop       = memtoreg_m | memwrite_m;
  assign lane        = aluout_m[1:0];
  assign is_byte     = (instr_m[27:26] == 2'b00);
  assign is_half     = (instr_m[27:26] == 2'b01);
  assign is_word     = ~is_byte & ~is_half;
  assign is_unsigned = instr_m[28];
  assign misaligned  = memop & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
  assign access      = memop & ~misaligned;
  assign timeout_hit = TO_EN && (state_reg == S_WAIT) && (cnt_reg == TO_LAST);

  assign dmem_addr = {aluout_m[31:2], 2'b00};
  assign dmem_we   = dmem_req & memwrite_m;

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = writedata_m;
    if (is_byte) begin
      dmem_be    = 4'b0001 << lane;
      dmem_wdata = {4{writedata_m[7:0]}};
    end else if (is_half) begin
      dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
      dmem_wdata = {2{writedata_m[15:0]}};
    end
  end

  // Aligned accesses guarantee the addressed data lands in the low bits after the shift.
  assign rshift = dmem_rdata >> {lane, 3'b000};

  always_comb begin
    load_data = rshift;
    if (is_byte)
      load_data = is_unsigned ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
    else if (is_half)
      load_data = is_unsigned ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (access && !dmem_ack) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end
      end
      S_WAIT: begin
        if (timeout_hit || dmem_ack)
          state_next = S_IDLE;
        else
          cnt_next = cnt_reg + CNT_W'(1);
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The timeout cycle drops the request, so an ack there is not accepted.
  always_comb begin
    dmem_req     = 1'b0;
    stall_m      = 1'b0;
    done         = 1'b0;
    buserr_hit   = 1'b0;
    misalign_hit = 1'b0;
    if (rst_n) begin
      case (state_reg)
        S_IDLE: begin
          misalign_hit = misaligned;
          if (access) begin
            dmem_req = 1'b1;
            done     = dmem_ack;
            stall_m  = ~dmem_ack;
          end
        end
        S_WAIT: begin
          if (timeout_hit) begin
            buserr_hit = 1'b1;
          end else begin
            dmem_req = 1'b1;
            done     = dmem_ack;
            stall_m  = ~dmem_ack;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syscall_w  <= 1'b0;
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
      readdata_w <= '0;
      aluout_w   <= '0;
      writereg_w <= '0;
      a0_w       <= '0;
      v0_w       <= '0;
      instr_w    <= '0;
      misalign_w <= 1'b0;
      buserr_w   <= 1'b0;
    end else if (stall_m || buserr_hit || misalign_hit) begin
      // Bubble: kill the writeback controls, keep the data fields as they were.
      syscall_w  <= 1'b0;
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
      misalign_w <= misalign_hit;
      buserr_w   <= buserr_hit;
    end else begin
      syscall_w  <= syscall_m;
      regwrite_w <= regwrite_m;
      memtoreg_w <= memtoreg_m;
      aluout_w   <= aluout_m;
      writereg_w <= writereg_m;
      a0_w       <= a0_m;
      v0_w       <= v0_m;
      instr_w    <= instr_m;
      misalign_w <= 1'b0;
      buserr_w   <= 1'b0;
      if (done && memtoreg_m)
        readdata_w <= load_data;
    end
  end

`ifdef MEM_WB_RESULT_EN
  assign result_w = memtoreg_w ? readdata_w : aluout_w;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a transaction-level model of the MEM access and MEM/WB register.
module tb_mem_wb_stage;
  localparam int TO    = 4;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        syscall_m, regwrite_m, memtoreg_m, memwrite_m;
  logic [31:0] aluout_m, writedata_m, a0_m, v0_m, instr_m;
  logic [4:0]  writereg_m;
  logic        dmem_req, dmem_we, dmem_ack, stall_m;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        syscall_w, regwrite_w, memtoreg_w, misalign_w, buserr_w;
  logic [31:0] readdata_w, aluout_w, a0_w, v0_w, instr_w;
  logic [4:0]  writereg_w;
`ifdef MEM_WB_RESULT_EN
  logic [31:0] result_w;
`endif

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .syscall_m(syscall_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
    .aluout_m(aluout_m), .writedata_m(writedata_m), .writereg_m(writereg_m),
    .a0_m(a0_m), .v0_m(v0_m), .instr_m(instr_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_m(stall_m),
    .syscall_w(syscall_w), .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w),
    .readdata_w(readdata_w), .aluout_w(aluout_w), .writereg_w(writereg_w),
    .a0_w(a0_w), .v0_w(v0_w), .instr_w(instr_w),
    .misalign_w(misalign_w), .buserr_w(buserr_w)
`ifdef MEM_WB_RESULT_EN
    , .result_w(result_w)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Expected bus-side values for the current cycle
  logic        e_req, e_stall, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata;
  // Expected MEM/WB register contents
  logic        m_syscall, m_regwrite, m_memtoreg, m_misalign, m_buserr;
  logic [31:0] m_readdata, m_aluout, m_a0, m_v0, m_instr;
  logic [4:0]  m_writereg;
  // Observations from the first cycle of the latest transaction
  logic        obs_req, obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata;
  int          n_stall;
  int          txn = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_syscall = 0; m_regwrite = 0; m_memtoreg = 0; m_misalign = 0; m_buserr = 0;
    m_readdata = 0; m_aluout = 0; m_a0 = 0; m_v0 = 0; m_instr = 0; m_writereg = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dmem_req", dmem_req, e_req);
      chk("stall_m", stall_m, e_stall);
      if (e_req) begin
        chk("dmem_we", dmem_we, e_we);
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_be", dmem_be, e_be);
        if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("syscall_w", syscall_w, m_syscall);
      chk("regwrite_w", regwrite_w, m_regwrite);
      chk("memtoreg_w", memtoreg_w, m_memtoreg);
      chk("readdata_w", readdata_w, m_readdata);
      chk("aluout_w", aluout_w, m_aluout);
      chk("writereg_w", writereg_w, m_writereg);
      chk("a0_w", a0_w, m_a0);
      chk("v0_w", v0_w, m_v0);
      chk("instr_w", instr_w, m_instr);
      chk("misalign_w", misalign_w, m_misalign);
      chk("buserr_w", buserr_w, m_buserr);
`ifdef MEM_WB_RESULT_EN
      chk("result_w", result_w, m_memtoreg ? m_readdata : m_aluout);
`endif
    end
  end

  // Present one instruction at posedge+1 and hold it until the stage lets it go.
  task automatic run_instr(input logic [5:0] op, input bit is_mem, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int delay);
    int size, sh, cyc;
    bit sgn, ld, st, mis, fin;
    logic [31:0] ldv;
    size = 4; sgn = 0; ld = 0; st = 0;
    if (is_mem) begin
      case (op)
        6'h20: begin size = 1; sgn = 1; ld = 1; end
        6'h21: begin size = 2; sgn = 1; ld = 1; end
        6'h23: begin size = 4; ld = 1; end
        6'h24: begin size = 1; ld = 1; end
        6'h25: begin size = 2; ld = 1; end
        6'h28: begin size = 1; st = 1; end
        6'h29: begin size = 2; st = 1; end
        default: begin size = 4; st = 1; end
      endcase
    end
    syscall_m   = (ld || st) ? 1'b0 : 1'($urandom_range(0, 1));
    regwrite_m  = ld ? 1'b1 : (st ? 1'b0 : 1'($urandom_range(0, 1)));
    memtoreg_m  = ld;
    memwrite_m  = st;
    aluout_m    = addr;
    writedata_m = wd;
    writereg_m  = 5'($urandom);
    a0_m        = $urandom;
    v0_m        = $urandom;
    instr_m     = {op, 26'($urandom)};
    dmem_rdata  = rd;
    mis = (ld || st) && (addr % size != 0);
    sh  = 8 * int'(addr % 4);
    ldv = rd >> sh;
    if (size == 1) begin
      ldv = ldv & 32'hFF;
      if (sgn && ldv > 127) ldv = ldv - 256;
    end else if (size == 2) begin
      ldv = ldv & 32'hFFFF;
      if (sgn && ldv > 32767) ldv = ldv - 65536;
    end
    e_addr  = (addr / 4) * 4;
    e_be    = (size == 1) ? 4'(32'd1 << (addr % 4)) : (size == 2) ? 4'(32'd3 << (addr % 4)) : 4'hF;
    e_wdata = (size == 1) ? (wd & 32'hFF) * 32'h01010101 :
              (size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    n_stall = 0;
    fin = 0;
    cyc = 0;
    for (int k = 0; k < 16 && !fin; k++) begin
      int oc;  // 0 capture, 1 stall bubble, 2 misalign bubble, 3 timeout bubble
      dmem_ack = ((ld || st) && !mis) ? (k == delay) : 1'($urandom_range(0, 1));
      if (!(ld || st))                begin e_req = 0; e_stall = 0; oc = 0; end
      else if (mis)                   begin e_req = 0; e_stall = 0; oc = 2; end
      else if (TO != 0 && k >= TO)    begin e_req = 0; e_stall = 0; oc = 3; end
      else if (k == delay)            begin e_req = 1; e_stall = 0; oc = 0; end
      else                            begin e_req = 1; e_stall = 1; oc = 1; end
      e_we = e_req && st;
      chk_en = 1;
      @(negedge clk);
      if (k == 0) begin
        obs_req = dmem_req; obs_we = dmem_we; obs_be = dmem_be;
        obs_addr = dmem_addr; obs_wdata = dmem_wdata;
      end
      if (stall_m) n_stall++;
      @(posedge clk);
      m_misalign = 0;
      m_buserr   = 0;
      if (oc == 0) begin
        m_syscall = syscall_m; m_regwrite = regwrite_m; m_memtoreg = memtoreg_m;
        m_aluout = aluout_m; m_writereg = writereg_m; m_a0 = a0_m; m_v0 = v0_m; m_instr = instr_m;
        if (ld) m_readdata = ldv;
      end else begin
        m_syscall = 0; m_regwrite = 0; m_memtoreg = 0;
        m_misalign = (oc == 2);
        m_buserr   = (oc == 3);
      end
      fin = (oc != 1);
      cyc = k + 1;
      #1;
    end
    dmem_ack = 0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL loop_bound actual=unfinished required=finished time=%0t", $time);
    end
    $display("txn %0d op=%h mem=%0d addr=%h delay=%0d cycles=%0d stalls=%0d",
             txn, op, is_mem, addr, delay, cyc, n_stall);
    txn++;
  endtask

  task automatic nop();
    run_instr(6'h00, 0, $urandom, $urandom, $urandom, 0);
  endtask

  logic [5:0] ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

  initial begin
    rst_n = 0; dmem_ack = 0; dmem_rdata = 0;
    syscall_m = 0; regwrite_m = 1; memtoreg_m = 1; memwrite_m = 0;
    aluout_m = 32'h40; writedata_m = 0; writereg_m = 5'd3; a0_m = 0; v0_m = 0;
    instr_m = {6'h23, 26'h0};
    model_reset();
    #12;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", stall_m, 1'b0);
    chk("rst_regwrite_w", regwrite_w, 1'b0);
    chk("rst_instr_w", instr_w, 32'h0);
    chk("rst_readdata_w", readdata_w, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;

    // sw, zero-wait
    run_instr(6'h2B, 1, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    chk("sw_req", obs_req, 1'b1);
    chk("sw_we", obs_we, 1'b1);
    chk("sw_be", obs_be, 4'hF);
    chk("sw_addr", obs_addr, 32'h100);
    chk("sw_stalls", n_stall, 0);
    chk("sw_regwrite_w", regwrite_w, 1'b0);

    // lb, three wait cycles
    run_instr(6'h20, 1, 32'h103, 32'h0, 32'h80FF0000, 3);
    chk("lb_stalls", n_stall, 3);
    chk("lb_readdata_w", readdata_w, 32'hFFFFFF80);
    chk("lb_regwrite_w", regwrite_w, 1'b1);

    run_instr(6'h25, 1, 32'h102, 32'h0, 32'hBEEF1234, 1);
    chk("lhu_be", obs_be, 4'hC);
    chk("lhu_readdata_w", readdata_w, 32'h0000BEEF);

    run_instr(6'h29, 1, 32'h102, 32'h00001234, 32'h0, 0);
    chk("sh_wdata", obs_wdata, 32'h12341234);
    chk("sh_be", obs_be, 4'hC);

    // misaligned word
    run_instr(6'h23, 1, 32'h101, 32'h0, 32'h55555555, 0);
    chk("mis_req", obs_req, 1'b0);
    chk("mis_stalls", n_stall, 0);
    chk("mis_flag", misalign_w, 1'b1);
    chk("mis_regwrite_w", regwrite_w, 1'b0);
    nop();
    chk("mis_flag_clear", misalign_w, 1'b0);

    // never-acked lw times out
    run_instr(6'h23, 1, 32'h300, 32'h0, 32'h0, NEVER);
    chk("to_stalls", n_stall, TO);
    chk("to_buserr", buserr_w, 1'b1);
    chk("to_regwrite_w", regwrite_w, 1'b0);
    nop();
    chk("to_buserr_clear", buserr_w, 1'b0);

    // reset in the middle of a waiting access
    chk_en = 0;
    regwrite_m = 1; memtoreg_m = 1; memwrite_m = 0; syscall_m = 0;
    instr_m = {6'h23, 26'h0}; aluout_m = 32'h200; dmem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("rstw_req", dmem_req, 1'b0);
    chk("rstw_stall", stall_m, 1'b0);
    chk("rstw_aluout_w", aluout_w, 32'h0);
    chk("rstw_instr_w", instr_w, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    run_instr(6'h23, 1, 32'h204, 32'h0, 32'hCAFEF00D, 1);
    chk("rstw_lw_readdata_w", readdata_w, 32'hCAFEF00D);
    chk("rstw_lw_regwrite_w", regwrite_w, 1'b1);

    // randomized mix
    for (int t = 0; t < 300; t++) begin
      int r, d;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        nop();
      end else begin
        d = $urandom_range(0, 9);
        run_instr(ops[$urandom_range(0, 7)], 1, $urandom, $urandom, $urandom,
                  (d >= 8) ? NEVER : (d % 4));
      end
    end
    nop();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
